// File: rtl/clock_pkg.sv
// Shared constants and the per-channel alarm state type for the multi-alarm clock.
package clock_pkg;

   localparam int DEF_NS  = 60;
   localparam int DEF_NM  = 60;
   localparam int DEF_NH  = 24;
   localparam int DEF_NW  = 7;
   localparam int DEF_NA  = 4;
   localparam int DEF_SNZ = 5;
   localparam int DEF_TMO = 10;
   // Bit 0 is Monday, so the low five bits select weekdays.
   localparam logic [DEF_NW-1:0] DEF_DAY_MASK = 7'b0011111;

   typedef enum logic [1:0] {
      IDLE,
      RING,
      SNOOZE
   } alarm_state_t;

endpackage

// File: rtl/ct_mod_n.sv
// Modulo-N up counter with enable and synchronous clear.
// wrap flags the edge on which an enabled count rolls N-1 -> 0.
module ct_mod_n #(
   parameter int N = 60,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic [W-1:0] nxt,
   output logic         wrap
);

   logic [W-1:0] q_reg;

   // nxt is the incremented value regardless of en, so callers can look ahead.
   assign nxt  = (q_reg == W'(N-1)) ? '0 : q_reg + 1'b1;
   assign wrap = en && (q_reg == W'(N-1));
   assign q    = q_reg;

   always_ff @(posedge clk) begin
      if (srst || clr) begin
         q_reg <= '0;
      end else if (en) begin
         q_reg <= nxt;
      end
   end

endmodule

// File: rtl/multi_alarm_clock.sv
// Day-of-week clock with NA independent alarm channels, each with its own
// day mask and an IDLE/RING/SNOOZE state machine driving one buzz bit.
module multi_alarm_clock
   import clock_pkg::*;
#(
   parameter int NS  = DEF_NS,
   parameter int NM  = DEF_NM,
   parameter int NH  = DEF_NH,
   parameter int NW  = DEF_NW,
   parameter int NA  = DEF_NA,
   parameter int SNZ = DEF_SNZ,
   parameter int TMO = DEF_TMO,
   parameter logic [NW-1:0] DEF_MASK = DEF_DAY_MASK
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Pulse,
   input  logic                  Timeset,
   input  logic                  Alarmset,
   input  logic [$clog2(NA)-1:0] Alarmsel,
   input  logic                  Minadv,
   input  logic                  Hrsadv,
   input  logic                  Dayadv,
   input  logic [NW-1:0]         Daymask,
   input  logic [NA-1:0]         Alarmon,
   input  logic                  Snooze,
   input  logic                  Stop,
   output logic [$clog2(NS)-1:0] Secs,
   output logic [$clog2(NM)-1:0] Mins,
   output logic [$clog2(NH)-1:0] Hrs,
   output logic [$clog2(NW)-1:0] Day,
   output logic [NA-1:0]         Buzz,
   output logic                  Buzzany
);

   localparam int SW   = $clog2(NS);
   localparam int MW   = $clog2(NM);
   localparam int HW   = $clog2(NH);
   localparam int DW   = $clog2(NW);
   localparam int AW   = $clog2(NA);
   localparam int CMAX = (SNZ > TMO) ? SNZ : TMO;
   localparam int CW   = $clog2(CMAX + 1);

   logic [SW-1:0] sec_q, sec_nxt;
   logic [MW-1:0] min_q, min_nxt;
   logic [HW-1:0] hr_q, hr_nxt;
   logic [DW-1:0] day_q, day_nxt;
   logic          sec_wrap, min_wrap, hr_wrap, day_wrap;
   logic          sec_en, min_en, hr_en, day_en;
   logic          alarm_mode;
   logic [HW-1:0] look_hr;
   logic [DW-1:0] look_day;
   logic [MW-1:0] alarm_min [NA];
   logic [HW-1:0] alarm_hr  [NA];
   logic [NA-1:0] buzz;
   logic          unused_bits;

   assign alarm_mode = Alarmset && !Timeset;

   // In set mode each field steps on its own advance input; in run mode carries chain.
   assign sec_en = Pulse && !Timeset;
   assign min_en = Timeset ? (Pulse && Minadv) : sec_wrap;
   assign hr_en  = Timeset ? (Pulse && Hrsadv) : min_wrap;
   assign day_en = Timeset ? (Pulse && Dayadv) : hr_wrap;

   ct_mod_n #(.N(NS)) u_sec (
      .clk(Clk), .srst(Reset), .en(sec_en), .clr(Timeset),
      .q(sec_q), .nxt(sec_nxt), .wrap(sec_wrap)
   );
   ct_mod_n #(.N(NM)) u_min (
      .clk(Clk), .srst(Reset), .en(min_en), .clr(1'b0),
      .q(min_q), .nxt(min_nxt), .wrap(min_wrap)
   );
   ct_mod_n #(.N(NH)) u_hr (
      .clk(Clk), .srst(Reset), .en(hr_en), .clr(1'b0),
      .q(hr_q), .nxt(hr_nxt), .wrap(hr_wrap)
   );
   ct_mod_n #(.N(NW)) u_day (
      .clk(Clk), .srst(Reset), .en(day_en), .clr(1'b0),
      .q(day_q), .nxt(day_nxt), .wrap(day_wrap)
   );

   assign unused_bits = ^{sec_nxt, day_wrap};

   // Time after a seconds rollover edge; only meaningful when sec_wrap is set.
   assign look_hr  = min_wrap ? hr_nxt  : hr_q;
   assign look_day = hr_wrap  ? day_nxt : day_q;

   for (genvar gi = 0; gi < NA; gi++) begin : g_ch
      logic [MW-1:0] amin_reg;
      logic [HW-1:0] ahr_reg;
      logic [NW-1:0] amask_reg;
      alarm_state_t  state_reg;
      logic [CW-1:0] ring_cnt_reg;
      logic [CW-1:0] snz_cnt_reg;
      logic          sel_hit;
      logic          match;
      logic          quiet;

      assign sel_hit = alarm_mode && (Alarmsel == AW'(gi));
      assign match   = sec_wrap && (min_nxt == amin_reg) && (look_hr == ahr_reg)
                       && amask_reg[look_day] && Alarmon[gi];
      assign quiet   = Stop || !Alarmon[gi];

      always_ff @(posedge Clk) begin
         if (Reset) begin
            amin_reg  <= '0;
            ahr_reg   <= '0;
            amask_reg <= DEF_MASK;
         end else begin
            if (sel_hit && Pulse && Minadv)
               amin_reg <= (amin_reg == MW'(NM-1)) ? '0 : amin_reg + 1'b1;
            if (sel_hit && Pulse && Hrsadv)
               ahr_reg <= (ahr_reg == HW'(NH-1)) ? '0 : ahr_reg + 1'b1;
            if (sel_hit && Dayadv)
               amask_reg <= Daymask;
         end
      end

      // sec_wrap is only ever set in run mode, so set-mode minute changes never count.
      always_ff @(posedge Clk) begin
         if (Reset) begin
            state_reg    <= IDLE;
            ring_cnt_reg <= '0;
            snz_cnt_reg  <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (match) begin
                     state_reg    <= RING;
                     ring_cnt_reg <= '0;
                  end
               end
               RING: begin
                  if (quiet) begin
                     state_reg <= IDLE;
                  end else if (Snooze) begin
                     state_reg   <= SNOOZE;
                     snz_cnt_reg <= '0;
                  end else if (sec_wrap) begin
                     if (ring_cnt_reg == CW'(TMO-1))
                        state_reg <= IDLE;
                     else
                        ring_cnt_reg <= ring_cnt_reg + 1'b1;
                  end
               end
               SNOOZE: begin
                  if (quiet) begin
                     state_reg <= IDLE;
                  end else if (sec_wrap) begin
                     if (snz_cnt_reg == CW'(SNZ-1)) begin
                        state_reg    <= RING;
                        ring_cnt_reg <= '0;
                     end else begin
                        snz_cnt_reg <= snz_cnt_reg + 1'b1;
                     end
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end

      assign alarm_min[gi] = amin_reg;
      assign alarm_hr[gi]  = ahr_reg;
      assign buzz[gi]      = (state_reg == RING);
   end

   assign Secs    = sec_q;
   assign Mins    = alarm_mode ? alarm_min[Alarmsel] : min_q;
   assign Hrs     = alarm_mode ? alarm_hr[Alarmsel]  : hr_q;
   assign Day     = day_q;
   assign Buzz    = buzz;
   assign Buzzany = |buzz;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with short snooze/timeout (SNZ=2, TMO=3).
module tb_multi_alarm_clock;

   localparam int NS = 60, NM = 60, NH = 24, NW = 7, NA = 4;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0, Pulse = 1'b0, Timeset = 1'b0, Alarmset = 1'b0;
   logic [1:0]    Alarmsel = '0;
   logic          Minadv = 1'b0, Hrsadv = 1'b0, Dayadv = 1'b0;
   logic [NW-1:0] Daymask = '0;
   logic [NA-1:0] Alarmon = '0;
   logic          Snooze = 1'b0, Stop = 1'b0;
   logic [5:0]    Secs, Mins;
   logic [4:0]    Hrs;
   logic [2:0]    Day;
   logic [NA-1:0] Buzz;
   logic          Buzzany;

   int total = 0;
   int bad   = 0;
   int cs = 0, cm = 0, ch = 0, cd = 0;

   always #5 Clk = ~Clk;

   multi_alarm_clock #(.SNZ(2), .TMO(3)) dut (
      .Clk(Clk), .Reset(Reset), .Pulse(Pulse), .Timeset(Timeset),
      .Alarmset(Alarmset), .Alarmsel(Alarmsel), .Minadv(Minadv),
      .Hrsadv(Hrsadv), .Dayadv(Dayadv), .Daymask(Daymask), .Alarmon(Alarmon),
      .Snooze(Snooze), .Stop(Stop), .Secs(Secs), .Mins(Mins), .Hrs(Hrs),
      .Day(Day), .Buzz(Buzz), .Buzzany(Buzzany)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick_model();
      cs++;
      if (cs == NS) begin
         cs = 0; cm++;
         if (cm == NM) begin
            cm = 0; ch++;
            if (ch == NH) begin
               ch = 0; cd = (cd + 1) % NW;
            end
         end
      end
   endtask

   task automatic check_time(input string tag);
      chk({tag, ".secs"}, int'(Secs), cs);
      chk({tag, ".mins"}, int'(Mins), cm);
      chk({tag, ".hrs"},  int'(Hrs),  ch);
      chk({tag, ".day"},  int'(Day),  cd);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      cs = 0; cm = 0; ch = 0; cd = 0;
   endtask

   task automatic run(input int n);
      Pulse = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         tick_model();
      end
      Pulse = 1'b0;
   endtask

   // Jump to day d, h:m:00 using set mode, one field step per Pulse.
   task automatic goto_time(input int d, input int h, input int m);
      int nd, nh, nm, n;
      nd = (d - cd + NW) % NW;
      nh = (h - ch + NH) % NH;
      nm = (m - cm + NM) % NM;
      n  = 1;
      if (nd > n) n = nd;
      if (nh > n) n = nh;
      if (nm > n) n = nm;
      Timeset = 1'b1;
      Pulse   = 1'b1;
      for (int i = 0; i < n; i++) begin
         Dayadv = (i < nd);
         Hrsadv = (i < nh);
         Minadv = (i < nm);
         step();
      end
      {Pulse, Dayadv, Hrsadv, Minadv, Timeset} = '0;
      cd = d; ch = h; cm = m; cs = 0;
   endtask

   // Step the selected alarm; leaves Alarmset high so the caller can read the display.
   task automatic alarm_adv(input int sel, input int nh, input int nm);
      int n;
      n = (nh > nm) ? nh : nm;
      if (n < 1) n = 1;
      Alarmset = 1'b1;
      Alarmsel = 2'(sel);
      Daymask  = '1;
      Pulse    = 1'b1;
      for (int i = 0; i < n; i++) begin
         Hrsadv = (i < nh);
         Minadv = (i < nm);
         step();
         tick_model();
      end
      {Pulse, Hrsadv, Minadv} = '0;
   endtask

   task automatic ctl(input logic snz, input logic stp);
      Snooze = snz;
      Stop   = stp;
      step();
      Snooze = 1'b0;
      Stop   = 1'b0;
   endtask

   initial begin
      #2;
      do_reset();
      chk("rst.secs", int'(Secs), 0);
      chk("rst.mins", int'(Mins), 0);
      chk("rst.hrs",  int'(Hrs), 0);
      chk("rst.day",  int'(Day), 0);
      chk("rst.buzz", int'(Buzz), 0);
      chk("rst.buzzany", int'(Buzzany), 0);

      run(61);
      chk("run61.secs", int'(Secs), 1);
      chk("run61.mins", int'(Mins), 1);
      chk("run61.buzz", int'(Buzz), 0);

      do_reset();
      goto_time(4, 7, 55);
      chk("tset.day",  int'(Day), 4);
      chk("tset.hrs",  int'(Hrs), 7);
      chk("tset.mins", int'(Mins), 55);
      chk("tset.secs", int'(Secs), 0);
      goto_time(4, 7, 0);
      chk("tset_wrap.mins", int'(Mins), 0);
      chk("tset_wrap.hrs",  int'(Hrs), 7);

      alarm_adv(0, 8, 1);
      chk("aset0.mins", int'(Mins), 1);
      chk("aset0.hrs",  int'(Hrs), 8);
      chk("aset0.day",  int'(Day), 4);
      Alarmset = 1'b0;
      Alarmon  = 4'b0001;
      #1;
      check_time("aset_run");

      goto_time(4, 7, 55);
      run(359);
      chk("pre_match.buzz", int'(Buzz), 0);
      run(1);
      chk("match_d4.buzz", int'(Buzz), 1);
      chk("match_d4.buzzany", int'(Buzzany), 1);
      chk("match_d4.hrs", int'(Hrs), 8);
      chk("match_d4.mins", int'(Mins), 1);
      chk("match_d4.secs", int'(Secs), 0);
      ctl(1'b0, 1'b1);
      chk("stop.buzz", int'(Buzz), 0);

      goto_time(5, 8, 0);
      run(60);
      chk("day5.buzz", int'(Buzz), 0);
      goto_time(6, 8, 0);
      run(60);
      chk("day6.buzz", int'(Buzz), 0);
      goto_time(0, 8, 0);
      run(60);
      chk("day0.buzz", int'(Buzz), 1);

      ctl(1'b1, 1'b0);
      chk("snooze.buzz", int'(Buzz), 0);
      run(119);
      chk("snooze_hold.buzz", int'(Buzz), 0);
      run(1);
      chk("reringing.buzz", int'(Buzz), 1);
      run(179);
      chk("pre_timeout.buzz", int'(Buzz), 1);
      run(1);
      chk("timeout.buzz", int'(Buzz), 0);
      chk("timeout.mins", int'(Mins), 6);
      check_time("timeout");

      alarm_adv(0, 4, 59);
      chk("aset0_12.hrs",  int'(Hrs), 12);
      chk("aset0_12.mins", int'(Mins), 0);
      alarm_adv(1, 12, 0);
      chk("aset1_12.hrs",  int'(Hrs), 12);
      chk("aset1_12.mins", int'(Mins), 0);
      Alarmset = 1'b0;
      Alarmon  = 4'b0011;
      goto_time(0, 11, 59);
      run(60);
      chk("dual.buzz", int'(Buzz), 3);
      ctl(1'b1, 1'b1);
      chk("dual_stop.buzz", int'(Buzz), 0);
      run(120);
      chk("dual_idle.buzz", int'(Buzz), 0);

      goto_time(0, 11, 59);
      run(60);
      chk("ring_again.buzz", int'(Buzz), 3);
      do_reset();
      chk("mid_ring_rst.buzz", int'(Buzz), 0);
      chk("mid_ring_rst.buzzany", int'(Buzzany), 0);
      check_time("mid_ring_rst");
      Alarmset = 1'b1;
      Alarmsel = 2'd0;
      #1;
      chk("rst_a0.hrs",  int'(Hrs), 0);
      chk("rst_a0.mins", int'(Mins), 0);
      Alarmsel = 2'd1;
      #1;
      chk("rst_a1.hrs",  int'(Hrs), 0);
      chk("rst_a1.mins", int'(Mins), 0);
      Alarmset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameters SHALL be: NS=60 (seconds/min), NM=60 (min/hr), NH=24 (hrs/day), NW=7 (days/week), NA=4 (alarm channels), SNZ=5 (snooze minutes), TMO=10 (ring timeout minutes), DEF_MASK=NW'b0011111 (day 0 = Monday; weekdays only).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning:
  Clk  in  1  system clock
  Reset  in  1  synchronous active-high reset
  Pulse  in  1  one-Clk-wide timebase tick; all time and alarm advances occur only on Clk edges with Pulse=1
  Timeset  in  1  current-time set mode
  Alarmset  in  1  alarm set mode
  Alarmsel  in  $clog2(NA)  alarm channel edited/displayed in alarm set mode
  Minadv  in  1  advance minutes by one per Pulse
  Hrsadv  in  1  advance hours by one per Pulse
  Dayadv  in  1  Timeset: advance day per Pulse; Alarmset: load Daymask
  Daymask  in  NW  day-enable mask for the selected alarm
  Alarmon  in  NA  per-channel alarm enable
  Snooze  in  1  snooze all ringing channels
  Stop  in  1  silence all ringing/snoozed channels
  Secs  out  $clog2(NS)  current seconds
  Mins  out  $clog2(NM)  current minutes, or selected alarm minutes in alarm set mode
  Hrs  out  $clog2(NH)  current hours, or selected alarm hours in alarm set mode
  Day  out  $clog2(NW)  current day (never replaced by alarm data)
  Buzz  out  NA  per-channel buzz
  Buzzany  out  1  OR of Buzz

Function
REQ-004 Run mode (Timeset=0): each Pulse, Secs SHALL increment; NS-1->0 carries to Mins; NM-1->0 carries to Hrs; NH-1->0 carries to Day; Day wraps NW-1->0.
REQ-005 While Timeset=1, Secs SHALL be held at 0; on each Pulse, Minadv, Hrsadv and Dayadv SHALL each independently increment their own field modulo its range, with no carry between fields.
REQ-006 Timeset=1 SHALL take priority over Alarmset=1; the two are never treated as both active.
REQ-007 While Alarmset=1 and Timeset=0: on each Pulse, Minadv/Hrsadv SHALL increment the selected alarm's minutes/hours modulo NM/NH with no carry. Any Clk edge with Dayadv=1 SHALL load Daymask into the selected alarm's mask. Current time SHALL keep running.
REQ-008 Match SHALL be: run mode; Pulse with Secs=NS-1, so the next time has Secs=0; next Hrs:Mins equals alarm i; next Day bit set in mask i; Alarmon[i]=1.
REQ-009 Each channel SHALL have an FSM with states IDLE, RING and SNOOZE; Buzz[i]=1 exactly in RING.
REQ-010 IDLE->RING on match, on the same Clk edge that rolls the time; the ring-minute counter clears.
REQ-011 RING->SNOOZE on Snooze=1; the snooze-minute counter clears.
REQ-012 RING->IDLE on Stop=1, or Alarmon[i]=0, or TMO minute carries while in RING.
REQ-013 SNOOZE->RING after SNZ minute carries; the ring-minute counter clears.
REQ-014 SNOOZE->IDLE on Stop=1 or Alarmon[i]=0.
REQ-015 Stop SHALL win over Snooze on the same edge; a match while in RING or SNOOZE SHALL be ignored.
REQ-016 Alarm edits SHALL not change FSM state.
REQ-017 Minute carries made during Timeset SHALL not count toward the SNZ or TMO counters.
REQ-018 All outputs SHALL be registered or decoded from registers; they SHALL not combinationally depend on Snooze, Stop or Pulse.

Reset
REQ-019 On Reset=1 at a Clk edge: time SHALL become 0:00:00 day 0; every alarm SHALL become 00:00 with mask DEF_MASK; all FSMs SHALL go to IDLE; the SNZ/TMO counters SHALL clear; Buzz SHALL be 0.
REQ-020 Reset SHALL override every other input, including mid-ring or mid-snooze.

Structure
REQ-021 Package clock_pkg SHALL hold the default parameter constants and the alarm state enum typedef (IDLE, RING, SNOOZE).
REQ-022 Sub-module ct_mod_n SHALL be a parametrised modulo-N counter with enable, synchronous clear and wrap flag; it is instantiated for Secs, Mins, Hrs and Day.

Verification
REQ-023 Bench, with SNZ=2 and TMO=3 overrides, SHALL cover these scenarios:
  Reset then 61 Pulses -> Secs=1, Mins=1, Buzz=0.
  Timeset with 55 Minadv, 7 Hrsadv and 4 Dayadv Pulses -> Day=4, Hrs=7, Mins=55, Secs=0, with no carry.
  Alarm 0 set to 08:01, default mask, Alarmon=01; run from day 4 07:55:00 -> Buzz[0]=1 at 08:01:00 day 4. Stop clears it. Day 5 and day 6 produce no buzz; day 0 buzzes again.
  Ringing, Snooze -> Buzz=0, then Buzz=1 again after 2 minute carries. No Stop -> Buzz=0 after 3 more minute carries.
  Alarms 0 and 1 both at 12:00 -> Buzz=11 on the same edge; Snooze and Stop together -> Buzz=00 and both FSMs IDLE.
  Reset asserted while ringing -> Buzz=0 next edge; Alarmset display shows 00:00 for both channels.
